line_feeder: RTL and testbench
==============================

# line_feeder

Upstream source for the per-line image-processing wrapper. For each line of a frame, the block requests the line from the frame reader and fills an on-chip line buffer. It then announces the line with a one-cycle READ_LINE_DONE pulse plus READ_POSY, and serves pixels to the wrapper's IN_DE/IN_DATA pull interface. WRITE_LINE_DONE from the wrapper is the credit that allows the next line to be announced.

## Interface
- WIDTH, 1600: pixels per line.
- HEIGHT, 1200: lines per frame.
- DW, 32: pixel word width, packed {R,G,B,pad}.
- AW, 11: line-buffer address width; requires 2^AW ≥ WIDTH.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- FRAME_START  in  1  pulse that starts a frame at line 0.
- LINE_REQ  out  1  line fetch request; held until acknowledged.
- LINE_REQ_Y  out  12  line number being requested.
- LINE_REQ_ACK  in  1  request accepted.
- SRC_VALID  in  1  source word valid.
- SRC_DATA  in  DW  source pixel word.
- SRC_READY  out  1  block can accept a source word.
- READ_LINE_DONE  out  1  one-cycle pulse: line buffered and first word is on IN_DATA.
- READ_POSY  out  12  line number of the announced line.
- IN_DE  in  1  consumer pop.
- IN_DATA  out  DW  current pixel; first-word-fall-through.
- WRITE_LINE_DONE  in  1  consumer finished writing the line (credit).
- FRAME_DONE  out  1  one-cycle pulse after the credit for line HEIGHT-1.
- BUSY  out  1  frame in progress.
- ERR  out  1  sticky: IN_DE while no line is announced or after WIDTH pops.

## Operation
- Fill FSM states: F_IDLE, F_REQ, F_FILL, F_WAIT.
  - F_IDLE → F_REQ on FRAME_START.
  - In F_REQ, LINE_REQ=1 with LINE_REQ_Y=fill_y.
  - F_REQ → F_FILL on LINE_REQ_ACK.
  - In F_FILL, SRC_READY=1 and each SRC_VALID&SRC_READY writes buf[wsel][wx]. wx counts 0..WIDTH-1.
  - At the last word, the buffer is marked full and fill_y increments.
  - After the last word: go to F_REQ if a free buffer exists and fill_y<HEIGHT, else F_WAIT. If fill_y==HEIGHT, go to F_IDLE.
  - F_WAIT → F_REQ when a buffer frees.
- Serve FSM states: S_IDLE, S_PRELOAD, S_ANNOUNCE, S_DRAIN, S_WAIT_WB.
  - S_IDLE → S_PRELOAD when buf[rsel] is full and the credit is available.
  - S_PRELOAD issues a read of address 0.
  - S_ANNOUNCE pulses READ_LINE_DONE, drives READ_POSY=serve_y, and IN_DATA holds word 0.
  - S_DRAIN: each IN_DE advances rx. The read address is rx+1 on the IN_DE cycle, so back-to-back IN_DE returns consecutive words.
  - After WIDTH pops, the buffer is freed, rsel toggles, and the FSM goes to S_WAIT_WB.
  - S_WAIT_WB → S_IDLE on WRITE_LINE_DONE; serve_y increments. If serve_y was HEIGHT-1, pulse FRAME_DONE and clear BUSY.
- The credit starts at 1 and is consumed at announce. WRITE_LINE_DONE restores it.
- IN_DE outside S_DRAIN is ignored (no pointer or data change) and sets ERR.
- FRAME_START while BUSY is ignored.
- SRC_VALID outside F_FILL is ignored.
- WRITE_LINE_DONE outside S_WAIT_WB is ignored.

## Timing
- Reset values: LINE_REQ=0, LINE_REQ_Y=0, SRC_READY=0, READ_LINE_DONE=0, READ_POSY=0, IN_DATA=0, FRAME_DONE=0, BUSY=0, ERR=0.
- Reset clears both FSMs, all pointers, full flags and the credit; buffer contents are not cleared. RST mid-line abandons the line and drops requests the next cycle.
- FRAME_START at cycle t: BUSY=1 and LINE_REQ=1 at t+1.
- Last source word of the first line accepted at t: preload read at t+1, READ_LINE_DONE=1 and IN_DATA=word0 at t+2.
- IN_DE at t: IN_DATA shows the next word at t+1.
- WRITE_LINE_DONE at t: the next announce is no earlier than t+3 (S_IDLE → S_PRELOAD → S_ANNOUNCE).
- A buffer free and a fill completion in the same cycle are both honoured: the fill goes to F_REQ directly.
- Counters are AW bits compared against WIDTH-1. Line counters are 12 bits compared against HEIGHT-1, with no wrap.

## Configuration
- LINE_FEEDER_PINGPONG_EN defined: two WIDTH-deep buffers. Fetch of line y+1 overlaps serving of line y.
- LINE_FEEDER_PINGPONG_EN undefined: one buffer, rsel=wsel=0. Fill waits in F_WAIT until the buffer is freed after WIDTH pops. Ports and timing of individual handshakes are unchanged.

## Structure
- Package line_feeder_pkg holds:
  - Default WIDTH and HEIGHT.
  - Fill and serve state enums.
  - Pixel word typedef.
- Sub-module line_feeder_bram: simple dual-port RAM, depth 2*2^AW (or 2^AW in single-buffer builds), 1-cycle registered read, read-during-write to a different address only.

## Test plan
- WIDTH=8, HEIGHT=2, ramp data 0..15, IN_DE continuous → READ_LINE_DONE twice with READ_POSY 0 then 1; IN_DATA sequences 0..7 and 8..15; FRAME_DONE after the second WRITE_LINE_DONE.
- Ping-pong build, SRC always valid, IN_DE slow (every 3rd cycle) → LINE_REQ_Y=1 issued before line 0 is drained; no data corruption.
- Single-buffer build, same stimulus → LINE_REQ for line 1 only after the 8th pop of line 0.
- WRITE_LINE_DONE withheld 50 cycles → no second READ_LINE_DONE until 3 cycles after it arrives.
- IN_DE before the first announce, and a 9th pop on WIDTH=8 → ERR=1; IN_DATA and pointers unchanged.
- RST asserted mid-fill of line 0, then FRAME_START → clean restart: LINE_REQ_Y=0 and correct data.

Source files
------------

// File: rtl/line_feeder_pkg.sv
// Shared types and defaults for the line feeder: geometry defaults,
// FSM state encodings and the pixel word type.
package line_feeder_pkg;

    localparam int WIDTH_DEF  = 1600;
    localparam int HEIGHT_DEF = 1200;
    localparam int DW_DEF     = 32;
    localparam int YW         = 12;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_FILL,
        F_WAIT
    } fill_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_ANNOUNCE,
        S_DRAIN,
        S_WAIT_WB
    } serve_state_t;

    // Packed {R,G,B,pad}
    typedef logic [DW_DEF-1:0] pixel_t;

endpackage

// File: rtl/line_feeder_if.sv
// Frame-reader, line-buffer and consumer handshakes of the line feeder.
// master = the feeder itself, slave = the surrounding wrapper/environment.
interface line_feeder_if #(
    parameter int DW = 32
);
    logic          FRAME_START;
    logic          LINE_REQ;
    logic [11:0]   LINE_REQ_Y;
    logic          LINE_REQ_ACK;
    logic          SRC_VALID;
    logic [DW-1:0] SRC_DATA;
    logic          SRC_READY;
    logic          READ_LINE_DONE;
    logic [11:0]   READ_POSY;
    logic          IN_DE;
    logic [DW-1:0] IN_DATA;
    logic          WRITE_LINE_DONE;
    logic          FRAME_DONE;
    logic          BUSY;
    logic          ERR;

    modport master (
        input  FRAME_START, LINE_REQ_ACK, SRC_VALID, SRC_DATA, IN_DE, WRITE_LINE_DONE,
        output LINE_REQ, LINE_REQ_Y, SRC_READY, READ_LINE_DONE, READ_POSY, IN_DATA,
               FRAME_DONE, BUSY, ERR
    );

    modport slave (
        output FRAME_START, LINE_REQ_ACK, SRC_VALID, SRC_DATA, IN_DE, WRITE_LINE_DONE,
        input  LINE_REQ, LINE_REQ_Y, SRC_READY, READ_LINE_DONE, READ_POSY, IN_DATA,
               FRAME_DONE, BUSY, ERR
    );

endinterface

// File: rtl/line_feeder_bram.sv
// Simple dual-port line-buffer RAM with a 1-cycle registered read.
// Only the read register is reset; array contents survive reset.
module line_feeder_bram #(
    parameter int DW  = 32,
    parameter int ABW = 11
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           wr_en_i,
    input  logic [ABW-1:0] wr_addr_i,
    input  logic [DW-1:0]  wr_data_i,
    input  logic           rd_en_i,
    input  logic [ABW-1:0] rd_addr_i,
    output logic [DW-1:0]  rd_data_o
);
    logic [DW-1:0] mem_q [2**ABW];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge CLK) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge CLK) begin
        if (RST)          rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_feeder.sv
// Line feeder: fetches frame lines into a line buffer and serves them to a
// pull consumer. Define LINE_FEEDER_PINGPONG_EN for two buffers (fetch overlaps serve).
//
// state      | meaning
// F_IDLE     | no frame being fetched
// F_REQ      | LINE_REQ raised for fill_y, waiting for ack
// F_FILL     | accepting WIDTH source words into buffer wsel
// F_WAIT     | line fetched, waiting for a free buffer
// S_IDLE     | waiting for a full buffer and the consumer credit
// S_PRELOAD  | reading word 0 of buffer rsel
// S_ANNOUNCE | READ_LINE_DONE pulse, word 0 on IN_DATA
// S_DRAIN    | serving pops until WIDTH words consumed
// S_WAIT_WB  | waiting for WRITE_LINE_DONE credit
module line_feeder
    import line_feeder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = 11
) (
    input logic           CLK,
    input logic           RST,
    line_feeder_if.master bus
);
`ifdef LINE_FEEDER_PINGPONG_EN
    localparam logic PP  = 1'b1;
    localparam int   BAW = AW + 1;
`else
    localparam logic PP  = 1'b0;
    localparam int   BAW = AW;
`endif
    localparam logic [AW-1:0] X_LAST = AW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    fill_state_t   f_state_q;
    serve_state_t  s_state_q;
    logic [AW-1:0] wx_q, rx_q;
    logic [YW-1:0] fill_y_q, serve_y_q, posy_q;
    logic          wsel_q, rsel_q;
    logic [1:0]    full_q;
    logic          credit_q, busy_q, err_q;
    logic          line_req_q, src_ready_q, rld_q, frame_done_q;

    logic          start, wr_en, fill_last, free_evt, nsel;
    logic          next_free, wait_free, line_ready, rd_en;
    logic [AW-1:0] rd_x;
    logic [DW-1:0] rd_data;

    assign start     = bus.FRAME_START && !busy_q;
    assign wr_en     = (f_state_q == F_FILL) && src_ready_q && bus.SRC_VALID;
    assign fill_last = wr_en && (wx_q == X_LAST);
    assign free_evt  = (s_state_q == S_DRAIN) && bus.IN_DE && (rx_q == X_LAST);

    // A buffer freed in the same cycle a fill completes still counts as free.
    assign nsel       = wsel_q ^ PP;
    assign next_free  = (!full_q[nsel] && (nsel != wsel_q)) || (free_evt && (rsel_q == nsel));
    assign wait_free  = !full_q[wsel_q] || (free_evt && (rsel_q == wsel_q));
    assign line_ready = full_q[rsel_q] || (fill_last && (wsel_q == rsel_q));

    always_ff @(posedge CLK) begin
        if (RST) begin
            f_state_q   <= F_IDLE;
            wx_q        <= '0;
            fill_y_q    <= '0;
            wsel_q      <= 1'b0;
            line_req_q  <= 1'b0;
            src_ready_q <= 1'b0;
        end else begin
            case (f_state_q)
                F_IDLE: if (start) begin
                    f_state_q  <= F_REQ;
                    line_req_q <= 1'b1;
                    fill_y_q   <= '0;
                    wx_q       <= '0;
                end
                F_REQ: if (bus.LINE_REQ_ACK) begin
                    f_state_q   <= F_FILL;
                    line_req_q  <= 1'b0;
                    src_ready_q <= 1'b1;
                end
                F_FILL: if (wr_en) begin
                    wx_q <= wx_q + 1'b1;
                    if (wx_q == X_LAST) begin
                        wx_q        <= '0;
                        fill_y_q    <= fill_y_q + 1'b1;
                        wsel_q      <= wsel_q ^ PP;
                        src_ready_q <= 1'b0;
                        if (fill_y_q == Y_LAST) begin
                            f_state_q <= F_IDLE;
                        end else if (next_free) begin
                            f_state_q  <= F_REQ;
                            line_req_q <= 1'b1;
                        end else begin
                            f_state_q <= F_WAIT;
                        end
                    end
                end
                F_WAIT: if (wait_free) begin
                    f_state_q  <= F_REQ;
                    line_req_q <= 1'b1;
                end
                default: f_state_q <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_state_q    <= S_IDLE;
            rx_q         <= '0;
            serve_y_q    <= '0;
            rsel_q       <= 1'b0;
            posy_q       <= '0;
            rld_q        <= 1'b0;
            frame_done_q <= 1'b0;
            credit_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rld_q        <= 1'b0;
            frame_done_q <= 1'b0;
            if (start) begin
                busy_q    <= 1'b1;
                credit_q  <= 1'b1;
                serve_y_q <= '0;
            end
            if (bus.IN_DE && (s_state_q != S_DRAIN)) err_q <= 1'b1;
            case (s_state_q)
                S_IDLE: if (line_ready && credit_q) s_state_q <= S_PRELOAD;
                S_PRELOAD: begin
                    s_state_q <= S_ANNOUNCE;
                    rld_q     <= 1'b1;
                    posy_q    <= serve_y_q;
                end
                S_ANNOUNCE: begin
                    s_state_q <= S_DRAIN;
                    credit_q  <= 1'b0;
                    rx_q      <= '0;
                end
                S_DRAIN: if (bus.IN_DE) begin
                    rx_q <= rx_q + 1'b1;
                    if (rx_q == X_LAST) begin
                        rx_q      <= '0;
                        rsel_q    <= rsel_q ^ PP;
                        s_state_q <= S_WAIT_WB;
                    end
                end
                S_WAIT_WB: if (bus.WRITE_LINE_DONE) begin
                    s_state_q <= S_IDLE;
                    credit_q  <= 1'b1;
                    serve_y_q <= serve_y_q + 1'b1;
                    if (serve_y_q == Y_LAST) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: s_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q <= '0;
        end else begin
            if (fill_last) full_q[wsel_q] <= 1'b1;
            if (free_evt)  full_q[rsel_q] <= 1'b0;
        end
    end

    // The last pop issues no read, so IN_DATA keeps the final word.
    assign rd_en = (s_state_q == S_PRELOAD) ||
                   ((s_state_q == S_DRAIN) && bus.IN_DE && (rx_q != X_LAST));
    assign rd_x  = (s_state_q == S_PRELOAD) ? '0 : rx_q + 1'b1;

    line_feeder_bram #(
        .DW  (DW),
        .ABW (BAW)
    ) u_bram (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en_i   (wr_en),
        .wr_addr_i (BAW'({wsel_q, wx_q})),
        .wr_data_i (bus.SRC_DATA),
        .rd_en_i   (rd_en),
        .rd_addr_i (BAW'({rsel_q, rd_x})),
        .rd_data_o (rd_data)
    );

    assign bus.LINE_REQ       = line_req_q;
    assign bus.LINE_REQ_Y     = fill_y_q;
    assign bus.SRC_READY      = src_ready_q;
    assign bus.READ_LINE_DONE = rld_q;
    assign bus.READ_POSY      = posy_q;
    assign bus.IN_DATA        = rd_data;
    assign bus.FRAME_DONE     = frame_done_q;
    assign bus.BUSY           = busy_q;
    assign bus.ERR            = err_q;

endmodule

// File: tb/tb_line_feeder.sv
// Scoreboard bench for line_feeder with WIDTH=8, HEIGHT=2: directed frames,
// expected pixels/line numbers queued by the stimulus and checked by a monitor.
module tb_line_feeder;
    import line_feeder_pkg::*;

    localparam int W   = 8;
    localparam int H   = 2;
    localparam int TMO = 300;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    pixel_t exp_px[$];
    int     exp_posy[$];
    bit     in_line;
    int     pops;

    int req1_cyc, last0_cyc, pop8_cyc;
    int ann_cyc [2];
    int wld_cyc [2];

    line_feeder_if #(.DW(32)) bus ();

    line_feeder #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DW     (32),
        .AW     (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.LINE_REQ;
            1:       return bus.READ_LINE_DONE;
            default: return bus.FRAME_DONE;
        endcase
    endfunction

    task automatic wait_ev(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_event_%0d: got none expected event within %0d cycles", which, TMO);
        end
    endtask

    // Scoreboard monitor: compares announcements and every popped word.
    always @(negedge clk) begin
        if (rst) begin
            in_line = 1'b0;
            pops    = 0;
        end else begin
            if (bus.READ_LINE_DONE) begin
                if (exp_posy.size() == 0) check("posy_unexpected", 1, 0);
                else                      check("read_posy", bus.READ_POSY, exp_posy.pop_front());
                in_line = 1'b1;
                pops    = 0;
            end
            if (bus.IN_DE && in_line) begin
                if (exp_px.size() == 0) check("px_unexpected", 1, 0);
                else                    check("in_data", bus.IN_DATA, exp_px.pop_front());
                pops++;
                if (pops == W) in_line = 1'b0;
            end
        end
    end

    task automatic reader(input int base);
        bit ok;
        int n;
        int to;
        for (int y = 0; y < H; y++) begin
            wait_ev(0, ok);
            if (!ok) return;
            check("line_req_y", bus.LINE_REQ_Y, y);
            if (y == 1) req1_cyc = cyc;
            @(posedge clk); #1 bus.LINE_REQ_ACK = 1'b1;
            @(posedge clk); #1 bus.LINE_REQ_ACK = 1'b0;
            bus.SRC_VALID = 1'b1;
            bus.SRC_DATA  = 32'(base + y * W);
            n  = 0;
            to = 0;
            while (n < W && to < TMO) begin
                @(negedge clk);
                if (bus.SRC_READY) begin
                    exp_px.push_back(bus.SRC_DATA);
                    n++;
                    if (n == W) begin
                        exp_posy.push_back(y);
                        if (y == 0) last0_cyc = cyc;
                    end
                    @(posedge clk); #1;
                    if (n < W) bus.SRC_DATA = 32'(base + y * W + n);
                    else       bus.SRC_VALID = 1'b0;
                end else begin
                    to++;
                end
            end
            if (n < W) begin
                check("src_fill_timeout", n, W);
                bus.SRC_VALID = 1'b0;
                return;
            end
        end
    endtask

    task automatic consumer(input int gap, input int wld0, input bit extra, input int base);
        bit ok;
        int d;
        for (int y = 0; y < H; y++) begin
            wait_ev(1, ok);
            if (!ok) return;
            ann_cyc[y] = cyc;
            for (int p = 0; p < W; p++) begin
                for (int g = 1; g < gap; g++) begin
                    @(posedge clk); #1 bus.IN_DE = 1'b0;
                end
                @(posedge clk); #1 bus.IN_DE = 1'b1;
                if (y == 0 && p == W - 1) pop8_cyc = cyc;
            end
            @(posedge clk); #1 bus.IN_DE = 1'b0;
            if (extra && y == 0) begin
                @(negedge clk);
                check("err_before_9th_pop", bus.ERR, 0);
                @(posedge clk); #1 bus.IN_DE = 1'b1;
                @(posedge clk); #1 bus.IN_DE = 1'b0;
                @(negedge clk);
                check("err_after_9th_pop", bus.ERR, 1);
                check("in_data_after_9th_pop", bus.IN_DATA, base + W - 1);
            end
            d = (y == 0) ? wld0 : 2;
            repeat (d) @(posedge clk);
            #1 bus.WRITE_LINE_DONE = 1'b1;
            wld_cyc[y] = cyc;
            @(posedge clk); #1 bus.WRITE_LINE_DONE = 1'b0;
        end
    endtask

    task automatic run_frame(input int base, input int gap, input int wld0, input bit extra);
        bit ok;
        @(posedge clk); #1 bus.FRAME_START = 1'b1;
        @(posedge clk); #1 bus.FRAME_START = 1'b0;
        @(negedge clk);
        check("busy_after_start", bus.BUSY, 1);
        check("line_req_after_start", bus.LINE_REQ, 1);
        fork
            reader(base);
            consumer(gap, wld0, extra, base);
        join
        wait_ev(2, ok);
        if (ok) begin
            check("frame_done_cycle", cyc, wld_cyc[1] + 1);
            check("busy_at_frame_done", bus.BUSY, 0);
        end
        @(negedge clk);
        check("frame_done_one_cycle", bus.FRAME_DONE, 0);
        check("px_queue_empty", exp_px.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.FRAME_START = 1'b0; bus.LINE_REQ_ACK = 1'b0; bus.SRC_VALID = 1'b0;
        bus.SRC_DATA = '0; bus.IN_DE = 1'b0; bus.WRITE_LINE_DONE = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_px.delete();
        exp_posy.delete();
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_line_req", bus.LINE_REQ, 0);
        check("rst_line_req_y", bus.LINE_REQ_Y, 0);
        check("rst_src_ready", bus.SRC_READY, 0);
        check("rst_read_line_done", bus.READ_LINE_DONE, 0);
        check("rst_read_posy", bus.READ_POSY, 0);
        check("rst_in_data", bus.IN_DATA, 0);
        check("rst_frame_done", bus.FRAME_DONE, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_err", bus.ERR, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        cyc = 0; n_checks = 0; n_fail = 0;
        rst = 1'b1;
        do_reset();
        check_reset_outputs();

        // Ramp 0..15, continuous pops
        run_frame(0, 1, 2, 1'b0);
        check("first_announce_latency", ann_cyc[0], last0_cyc + 2);

        // Slow consumer: pop every 3rd cycle
        run_frame(32, 3, 2, 1'b0);
`ifdef LINE_FEEDER_PINGPONG_EN
        check("req1_before_drain", req1_cyc < pop8_cyc, 1);
`else
        check("req1_after_8th_pop", req1_cyc > pop8_cyc, 1);
`endif

        // Credit withheld for 50 cycles
        run_frame(64, 1, 50, 1'b0);
        check("announce_after_credit", ann_cyc[1], wld_cyc[0] + 3);
        check("err_clean", bus.ERR, 0);

        // Pop with no line announced
        @(posedge clk); #1 bus.IN_DE = 1'b1;
        @(posedge clk); #1 bus.IN_DE = 1'b0;
        @(negedge clk);
        check("err_early_pop", bus.ERR, 1);
        check("in_data_hold_early_pop", bus.IN_DATA, 64 + 2 * W - 1);
        run_frame(128, 1, 2, 1'b0);
        check("err_sticky", bus.ERR, 1);

        do_reset();
        check_reset_outputs();
        run_frame(160, 1, 2, 1'b1);

        // Reset in the middle of filling line 0
        do_reset();
        @(posedge clk); #1 bus.FRAME_START = 1'b1;
        @(posedge clk); #1 bus.FRAME_START = 1'b0;
        wait_ev(0, ok);
        @(posedge clk); #1 bus.LINE_REQ_ACK = 1'b1;
        @(posedge clk); #1 bus.LINE_REQ_ACK = 1'b0;
        bus.SRC_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.SRC_DATA = 32'hDEAD_0000 + 32'(i);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.SRC_VALID = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midfill_rst_line_req", bus.LINE_REQ, 0);
        check("midfill_rst_src_ready", bus.SRC_READY, 0);
        check("midfill_rst_busy", bus.BUSY, 0);
        run_frame(192, 1, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
